dvp_frame_tx: RTL and testbench

- DVP camera-interface transmitter (sensor emulator) on the cam_pclk domain.
- Takes RGB565 pixels over a valid/ready stream and drives cam_vsync, cam_href and an 8-bit cam_data bus: high byte first, then low byte.
- Used to loop frames back into the camera capture path and to drive the downstream display/recognition pipeline without a physical OV5640.

---
 rtl/dvp_pkg.sv | 38 +++
 rtl/dvp_timing_gen.sv | 110 +++++++++++
 rtl/dvp_frame_tx.sv | 104 ++++++++++
 tb/tb_dvp_frame_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared state encoding, colour-bar palette and line-length helper for the DVP transmitter
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } dvp_state_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic int line_len(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// rtl/dvp_timing_gen.sv - free-running column/line counters and frame FSM producing registered DVP strobes
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
`ifdef DVP_TX_PATTERN_EN
  output logic [CNT_W-1:0] col,
`endif
  output logic             vsync,
  output logic             href,
  output logic             byte_hi,
  output logic             slot,
  output logic             frame_done
);

  localparam int LINE_LEN = line_len(H_ACTIVE, H_BLANK);
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] HREF_END  = CNT_W'(2 * H_ACTIVE);
  localparam logic [CNT_W-1:0] ODD_LIMIT = CNT_W'(2 * H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VSYNC_LINES - 1);
  localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(V_BACK - 1);
  localparam logic [CNT_W-1:0] VA_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VF_LAST   = CNT_W'(V_FRONT - 1);

  if (LINE_LEN >= (1 << CNT_W) || H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 ||
      VSYNC_LINES < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_bad_params
    $error("dvp_timing_gen: timing parameters out of range");
  end

  dvp_state_e       state_d, state_q;
  logic [CNT_W-1:0] col_d, col_q, line_d, line_q;
  logic             vsync_d, vsync_q, href_d, href_q, byte_hi_d, byte_hi_q;
  logic             slot_d, slot_q, frame_done_d, frame_done_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    col_d   = col_q + 1'b1;
    if (col_q == LAST_COL) begin
      col_d  = '0;
      line_d = line_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          line_d = '0;
          if (tx_en) state_d = ST_VSYNC;
        end
        ST_VSYNC:  if (line_q == VS_LAST) begin line_d = '0; state_d = ST_VBACK;  end
        ST_VBACK:  if (line_q == VB_LAST) begin line_d = '0; state_d = ST_ACTIVE; end
        ST_ACTIVE: if (line_q == VA_LAST) begin line_d = '0; state_d = ST_VFRONT; end
        ST_VFRONT: if (line_q == VF_LAST) begin
          line_d  = '0;
          state_d = tx_en ? ST_VSYNC : ST_IDLE;
        end
        default: begin line_d = '0; state_d = ST_IDLE; end
      endcase
    end

    // Strobes are derived from next-state so each one lines up with the counters it describes.
    vsync_d   = (state_d == ST_VSYNC);
    href_d    = (state_d == ST_ACTIVE) && (col_d < HREF_END);
    byte_hi_d = href_d && !col_d[0];
    slot_d    = ((state_d == ST_ACTIVE) && col_d[0] && (col_d < ODD_LIMIT)) ||
                ((col_d == LAST_COL) &&
                 (((state_d == ST_VBACK) && (line_d == VB_LAST)) ||
                  ((state_d == ST_ACTIVE) && (line_d != VA_LAST))));
    frame_done_d = (state_d == ST_VFRONT) && (col_d == LAST_COL) && (line_d == VF_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      line_q       <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      byte_hi_q    <= 1'b0;
      slot_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      byte_hi_q    <= byte_hi_d;
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DVP_TX_PATTERN_EN
  assign col = col_q;
`endif
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign byte_hi    = byte_hi_q;
  assign slot       = slot_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/dvp_frame_tx.sv
// rtl/dvp_frame_tx.sv - DVP sensor emulator: RGB565 stream to vsync/href/byte bus; DVP_TX_PATTERN_EN adds colour bars
module dvp_frame_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 8,
  parameter int CNT_W       = 12
) (
  input  logic        cam_pclk,
  input  logic        rst,
  input  logic        tx_en,
`ifdef DVP_TX_PATTERN_EN
  input  logic        pat_sel,
`endif
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        underrun
);

  logic        slot, byte_hi, use_stream;
  logic [15:0] stream_pix, src_pix;
  logic [7:0]  cam_data_d, cam_data_q, low_d, low_q;
  logic        underrun_d, underrun_q;

`ifdef DVP_TX_PATTERN_EN
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(line_len(H_ACTIVE, H_BLANK) - 1);
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [CNT_W-1:0] col, next_pix, bar_q;
  logic [2:0]       bar_idx;
`endif

  dvp_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .CNT_W(CNT_W)
  ) u_timing (
    .clk        (cam_pclk),
    .rst        (rst),
    .tx_en      (tx_en),
`ifdef DVP_TX_PATTERN_EN
    .col        (col),
`endif
    .vsync      (cam_vsync),
    .href       (cam_href),
    .byte_hi    (byte_hi),
    .slot       (slot),
    .frame_done (frame_done)
  );

  assign stream_pix = pix_valid ? pix_data : 16'h0000;

`ifdef DVP_TX_PATTERN_EN
  // The slot precedes the pixel's first byte, so the bar is chosen for the upcoming column.
  always_comb begin
    next_pix = (col == LAST_COL) ? '0 : ((col + 1'b1) >> 1);
    bar_q    = next_pix / CNT_W'(BAR_W);
    bar_idx  = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
  end
  assign use_stream = !pat_sel;
  assign src_pix    = pat_sel ? bar_color(bar_idx) : stream_pix;
`else
  assign use_stream = 1'b1;
  assign src_pix    = stream_pix;
`endif

  assign pix_ready = slot && use_stream;

  always_comb begin
    cam_data_d = 8'h00;
    low_d      = low_q;
    underrun_d = underrun_q;
    if (slot) begin
      cam_data_d = src_pix[15:8];
      low_d      = src_pix[7:0];
      if (use_stream && !pix_valid) underrun_d = 1'b1;
    end else if (byte_hi) begin
      cam_data_d = low_q;
    end
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      cam_data_q <= 8'h00;
      low_q      <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      cam_data_q <= cam_data_d;
      low_q      <= low_d;
      underrun_q <= underrun_d;
    end
  end

  assign cam_data = cam_data_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// tb/tb_dvp_frame_tx.sv - scoreboard bench for dvp_frame_tx with a 4x2 frame (LINE_LEN 11, 55-cycle frame)
module tb_dvp_frame_tx;

  localparam int FRAME = 55;

  logic        clk, rst, tx_en, pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready, cam_vsync, cam_href, frame_done, underrun;
  logic [7:0]  cam_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [15:0] pix_tab [16] = '{16'h1234, 16'hABCD, 16'h5A5A, 16'h0F0F, 16'hFFFF, 16'h8001,
                                16'h00FF, 16'hC3C3, 16'h7E81, 16'h2468, 16'hFEDC, 16'h1357,
                                16'h9999, 16'h0001, 16'h8000, 16'h6B2D};
  int  slot_n = 0;
  int  drop_at = -1;
  bit  mon_en = 0;
  bit  running = 0;
  int  k = 0;
  int  fd_cnt = 0;

  dvp_frame_tx #(
    .H_ACTIVE(4), .H_BLANK(3), .V_ACTIVE(2), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .CNT_W(12)
  ) dut (
    .cam_pclk   (clk),
    .rst        (rst),
    .tx_en      (tx_en),
`ifdef DVP_TX_PATTERN_EN
    .pat_sel    (1'b0),
`endif
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_href(input int pos);
    return (pos >= 22) && (pos < 44) && (((pos - 22) % 11) < 8);
  endfunction

  // Driver: feeds the next table pixel in each ready slot and records the bytes it should produce.
  initial begin
    logic [15:0] p;
    forever begin
      @(negedge clk);
      pix_valid = 1'b1;
      if (pix_ready && !rst) begin
        p = pix_tab[slot_n % 16];
        pix_data = p;
        if (slot_n == drop_at) begin
          pix_valid = 1'b0;
          exp_q.push_back(8'h00);
          exp_q.push_back(8'h00);
        end else begin
          exp_q.push_back(p[15:8]);
          exp_q.push_back(p[7:0]);
        end
        slot_n++;
      end
    end
  end

  // Monitor: frame-position model for the strobes plus byte scoreboard.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (frame_done) fd_cnt++;
        if (running) begin
          k++;
          if (k == FRAME) begin
            if (tx_en) k = 0;
            else running = 0;
          end
        end else if (cam_vsync) begin
          running = 1;
          k = 0;
        end
        if (running) begin
          chk("vsync", cam_vsync, (k < 11));
          chk("href", cam_href, exp_href(k));
          chk("frame_done", frame_done, (k == FRAME - 1));
        end else begin
          chk("idle_href", cam_href, 0);
          chk("idle_frame_done", frame_done, 0);
        end
        if (cam_href) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got byte %0h with no expected entry", cam_data);
          end else begin
            b = exp_q.pop_front();
            chk("cam_data", cam_data, b);
          end
        end else begin
          chk("blank_data", cam_data, 0);
        end
      end
    end
  end

  task automatic wait_vsync(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (cam_vsync) begin ok = 1; break; end
    end
  endtask

  task automatic wait_href(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (cam_href) begin ok = 1; break; end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"}, cam_vsync, 0);
    chk({tag, "_href"}, cam_href, 0);
    chk({tag, "_data"}, cam_data, 0);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    bit ok;
    int fd0, vs_cnt, href_cnt;
    rst = 1'b1;
    tx_en = 1'b0;
    pix_valid = 1'b1;
    pix_data = 16'h0000;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    mon_en = 1;
    repeat (5) @(negedge clk);
    chk_all_zero("idle");

    // Free-running frames with a continuous stream.
    tx_en = 1'b1;
    wait_vsync(30, ok);
    chk("start_vsync_seen", ok, 1);
    repeat (3 * FRAME) @(posedge clk);
    #1;
    chk("no_underrun", underrun, 0);

    // Underrun on the third slot of the next frame.
    wait_vsync(FRAME + 5, ok);
    chk("underrun_frame_vsync", ok, 1);
    drop_at = slot_n + 2;
    repeat (FRAME) @(posedge clk);
    #1;
    chk("underrun_set", underrun, 1);
    repeat (2 * FRAME) @(posedge clk);
    #1;
    chk("underrun_sticky", underrun, 1);

    // Stop mid-ACTIVE: frame completes, then idle.
    wait_href(FRAME + 5, ok);
    chk("stop_href_seen", ok, 1);
    @(negedge clk);
    tx_en = 1'b0;
    fd0 = fd_cnt;
    repeat (FRAME + 5) @(posedge clk);
    #1;
    chk("stop_one_frame_done", fd_cnt - fd0, 1);
    chk("stop_queue_drained", exp_q.size(), 0);
    vs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (cam_vsync) vs_cnt++;
    end
    chk("stop_no_vsync", vs_cnt, 0);
    chk("stop_no_more_frame_done", fd_cnt - fd0, 1);

    // Asynchronous reset during href.
    @(negedge clk);
    tx_en = 1'b1;
    wait_href(2 * FRAME, ok);
    chk("rst_href_seen", ok, 1);
    @(negedge clk);
    mon_en = 0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    running = 0;
    drop_at = -1;
    slot_n = 0;
    mon_en = 1;
    href_cnt = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (cam_vsync) begin ok = 1; break; end
      if (cam_href) href_cnt++;
    end
    chk("post_rst_vsync_seen", ok, 1);
    chk("post_rst_no_partial", href_cnt, 0);
    chk("post_rst_underrun_clear", underrun, 0);
    fd0 = fd_cnt;
    repeat (FRAME - 2) @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (FRAME) @(posedge clk);
    #1;
    chk("post_rst_frame_done", fd_cnt - fd0, 1);
    chk("post_rst_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
